// File: rtl/cm_fifo_pkg.sv
// cm_fifo_pkg: entry encoding and write-state type shared by the CM FIFO write and read sides.
package cm_fifo_pkg;
  typedef logic [8:0] entry_t;
  localparam int CTRL_BIT = 8;
  localparam entry_t PAD_ENTRY = 9'h100;
  localparam entry_t EOP_ENTRY = 9'h101;
  typedef enum logic [1:0] {EMPTY, HALF, TAIL} wr_state_t;
  function automatic entry_t data_entry(input logic [7:0] b);
    return {1'b0, b};
  endfunction
  function automatic logic is_ctrl(input entry_t e);
    return e[CTRL_BIT];
  endfunction
endpackage

// File: rtl/cm_fifo_wr_timer.sv
// cm_fifo_wr_timer: saturating wait counter for a lone low entry; hit never fires when TIMEOUT is 0.
module cm_fifo_wr_timer #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic push_clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [7:0] cnt;
  always_ff @(posedge push_clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : (en && cnt != TIMEOUT) ? cnt + 8'd1 : cnt;
  assign hit = (TIMEOUT != 8'd0) && (cnt == TIMEOUT);
endmodule

// File: rtl/cm_fifo_wr_packer.sv
// cm_fifo_wr_packer: packs tagged 9-bit byte/control entries into 18-bit FIFO words, low half first.
module cm_fifo_wr_packer
  import cm_fifo_pkg::*;
#(
  parameter logic [3:0] PF_STOP = 4'd2,
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        push_clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  input  logic        flush,
  output logic        fifo_push,
  output logic [17:0] fifo_din,
  input  logic [3:0]  fifo_push_flag,
  input  logic        fifo_overflow,
  input  logic        err_clr,
  output logic        ovf_err,
  output logic [15:0] pkt_count,
  output logic        busy
);
  wr_state_t   state, state_n;
  entry_t      lo, lo_n;
  logic [17:0] din_n;
  logic        space, accept, hit, push_n, pkt_inc, flush_pend, flush_pend_n, go_pad;
  assign space      = fifo_push_flag > PF_STOP;
  assign byte_ready = !rst && space && (state == EMPTY || state == HALF);
  assign accept     = byte_valid && byte_ready;
  assign busy       = (state != EMPTY) || fifo_push;
  assign go_pad     = (flush || flush_pend || hit) && space;
  cm_fifo_wr_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .push_clk (push_clk),
    .rst      (rst),
    .clr      (state != HALF),
    .en       (state == HALF),
    .hit      (hit)
  );
  always_comb begin
    state_n = state;
    lo_n    = lo;
    push_n  = 1'b0;
    din_n   = fifo_din;
    pkt_inc = 1'b0;
    if (state == EMPTY && accept) begin
      push_n  = byte_last;
      pkt_inc = byte_last;
      din_n   = byte_last ? {EOP_ENTRY, data_entry(byte_data)} : fifo_din;
      lo_n    = data_entry(byte_data);
      state_n = byte_last ? EMPTY : HALF;
    end else if (state == HALF && accept) begin
      push_n  = 1'b1;
      din_n   = {data_entry(byte_data), lo};
      lo_n    = byte_last ? EOP_ENTRY : lo;
      state_n = byte_last ? TAIL : EMPTY;
    end else if (state == HALF && go_pad) begin
      push_n  = 1'b1;
      din_n   = {PAD_ENTRY, lo};
      state_n = EMPTY;
    end else if (state == TAIL && space) begin
      push_n  = 1'b1;
      pkt_inc = 1'b1;
      din_n   = {PAD_ENTRY, EOP_ENTRY};
      state_n = EMPTY;
    end
    // a flush that meets a full FIFO is remembered until space returns
    flush_pend_n = (state == HALF) && (state_n == HALF) && (flush || flush_pend);
  end
  always_ff @(posedge push_clk or posedge rst)
    if (rst) begin
      state      <= EMPTY;
      lo         <= '0;
      flush_pend <= 1'b0;
      fifo_push  <= 1'b0;
      fifo_din   <= '0;
      pkt_count  <= '0;
      ovf_err    <= 1'b0;
    end else begin
      state      <= state_n;
      lo         <= lo_n;
      flush_pend <= flush_pend_n;
      fifo_push  <= push_n;
      fifo_din   <= din_n;
      pkt_count  <= pkt_count + {15'd0, pkt_inc};
      ovf_err    <= fifo_overflow ? 1'b1 : err_clr ? 1'b0 : ovf_err;
    end
endmodule

// File: doc/cm_fifo_wr_packer.md
Name: cm_fifo_wr_packer

Overview:
Upstream write-side stage for the Communication Manager FIFO. Accepts a byte stream from the fabric (valid/ready with end-of-packet), tags each byte into a 9-bit entry and pairs entries into 18-bit FIFO words, low half first. Drives the FIFO push port and throttles on the FIFO push-level flag. Odd tails are padded so the 9-bit read side always sees complete, self-describing entries.

Parameters:
PF_STOP, 4'd2, byte_ready deasserts when fifo_push_flag <= PF_STOP; absorbs push-pipeline latency.
TIMEOUT, 8'd64, cycles a lone low entry may wait in HALF before an automatic pad flush; 0 disables.
PAD_ENTRY, 9'h100, control entry used as filler.
EOP_ENTRY, 9'h101, control entry marking end of packet.

Ports:
push_clk  in  1  write clock.
rst  in  1  reset.
byte_valid  in  1  source byte valid.
byte_data  in  8  source byte.
byte_last  in  1  byte is the last of its packet.
byte_ready  out  1  byte accepted when byte_valid && byte_ready.
flush  in  1  single-cycle request to push a pending half word immediately.
fifo_push  out  1  FIFO push strobe, registered.
fifo_din  out  18  FIFO write data, registered; [8:0] is read out first.
fifo_push_flag  in  4  FIFO write-side fill flag; 0 = full.
fifo_overflow  in  1  FIFO overflow indication.
err_clr  in  1  clears ovf_err.
ovf_err  out  1  sticky; set by fifo_overflow.
pkt_count  out  16  wrapping count of EOP entries written.
busy  out  1  state != EMPTY or fifo_push asserted.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is push_clk. Reset state is EMPTY. All of fifo_push, fifo_din, ovf_err, pkt_count and busy reset to 0; byte_ready is 0 while rst is asserted.
- Entry format: bit8 = 0 marks a data byte {1'b0, byte}; bit8 = 1 marks a control entry (PAD_ENTRY or EOP_ENTRY).
- space = (fifo_push_flag > PF_STOP). byte_ready = space && (state == EMPTY || state == HALF).
- EMPTY:
  - accept, !last: lo <= {0, byte}; go to HALF.
  - accept, last: push {EOP_ENTRY, {0, byte}}; stay in EMPTY; pkt_count++.
- HALF:
  - accept, !last: push {{0, byte}, lo}; go to EMPTY.
  - accept, last: push {{0, byte}, lo}; lo <= EOP_ENTRY; go to TAIL.
  - no accept and (flush or timer == TIMEOUT, TIMEOUT != 0), gated by space: push {PAD_ENTRY, lo}; go to EMPTY.
  - Acceptance takes priority over flush or timeout in the same cycle.
- TAIL: when space, push {PAD_ENTRY, EOP_ENTRY}; pkt_count++; go to EMPTY. byte_ready stays 0 in TAIL.
- Push timing: fifo_push is a one-cycle pulse, registered, one cycle after the deciding edge. fifo_din holds its value between pushes. At most one push per cycle.
- Timer:
  - Cleared on entry to HALF, incremented each cycle in HALF, saturates at TIMEOUT.
  - flush in EMPTY or TAIL is ignored.
  - If space is low at the deadline, the flush is held until space returns.
- A packet of N bytes produces N+1 entries, padded to an even count. The next packet always starts word-aligned.
- ovf_err: set on fifo_overflow; err_clr clears it. If both occur in the same cycle, set wins.
- pkt_count wraps from 16'hFFFF to 0.
- Reset mid-packet: the pending half word is discarded and no pad is emitted.

Decomposition:
- Shared package cm_fifo_pkg: PAD_ENTRY, EOP_ENTRY, the entry bit8 control-flag definition, and the state enum {EMPTY, HALF, TAIL}. The 9-bit read-side consumer uses the same package.
- One sub-module, cm_fifo_wr_timer: the saturating HALF-state timeout counter with clear, enable and hit outputs.

Test Plan:
- Bytes 0x11, 0x22, 0x33(last), fifo_push_flag = 4'hF -> two pushes: 18'h04411, then {EOP_ENTRY, 9'h033} = 18'h20233; pkt_count = 1.
- Bytes 0xA0, 0xA1(last) -> pushes 18'h142A0, then {PAD_ENTRY, EOP_ENTRY} = 18'h20101; byte_ready is 0 during TAIL.
- Byte 0x5A (not last), then idle with TIMEOUT = 4 -> exactly one push 18'h2005A after the timeout expires; state returns to EMPTY.
- fifo_push_flag = 2 while in HALF with flush pulsed -> byte_ready = 0 and no push; raise flag to 5 -> pad push issued one cycle later.
- Assert rst while in HALF holding 0x77 -> no push, outputs 0, state EMPTY; the next packet starts word-aligned.
- fifo_overflow pulse with err_clr in the same cycle -> ovf_err = 1; err_clr alone -> ovf_err = 0.
